shift_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 16-bit shifter datapath.
- Accepts one shift request: data, 4-bit amount, op.
- Executes it as a series of single power-of-two stage passes (8, 4, 2, 1), one pass per clock, reusing one internal stage.
- Sits between the execute-stage control and the shifter, trading latency for area; reports completion with Busy/Done.

---
 rtl/shift_seq_ctrl.sv | 94 +++++++++
 tb/tb_shift_seq_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: applies a 4-bit shift amount as successive
// power-of-two passes (8, 4, 2, 1) through one shared stage, one pass per clock.
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Out
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] out_q, out_d;
    logic [3:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  sel;

    // One stage pass; s is always a single power of two (1, 2, 4 or 8).
    function automatic logic [15:0] stage_pass(input logic [15:0] d, input logic [1:0] op,
                                               input logic [3:0] s);
        logic [4:0]  sw;
        logic [15:0] r;
        sw = {1'b0, s};
        case (op)
            2'b00:   r = (d << sw) | (d >> (5'd16 - sw));
            2'b01:   r = d << sw;
            2'b10:   r = 16'($signed(d) >>> sw);
            default: r = d >> sw;
        endcase
        return r;
    endfunction

    // One-hot of the highest remaining bit; its numeric value is the pass amount.
    always_comb begin
        sel = 4'b0000;
        if (rem_q[3])      sel = 4'b1000;
        else if (rem_q[2]) sel = 4'b0100;
        else if (rem_q[1]) sel = 4'b0010;
        else if (rem_q[0]) sel = 4'b0001;
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    out_d   = In;
                    rem_d   = Cnt;
                    op_d    = Op;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (rem_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    out_d = stage_pass(out_q, op_q, sel);
                    rem_d = rem_q & ~sel;
                    if ((rem_q & ~sel) == 4'd0) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= 16'h0000;
            rem_q   <= 4'd0;
            op_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign Done = (state_q == StDone);
    assign Out  = out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a cycle-level behavioural model
// (bit-at-a-time shifting, popcount latency) plus directed literal checks.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, Start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic        Busy, Done;
    logic [15:0] Out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: remaining busy cycles, done flag, visible result, pending result.
    int          m_bl   = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_out  = 16'h0000;
    logic [15:0] m_res  = 16'h0000;

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Busy  (Busy),
        .Done  (Done),
        .Out   (Out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                              input logic [1:0] o);
        logic [15:0] x;
        x = d;
        for (int i = 0; i < int'(c); i++) begin
            case (o)
                2'b00:   x = {x[14:0], x[15]};
                2'b01:   x = {x[14:0], 1'b0};
                2'b10:   x = {x[15], x[15:1]};
                default: x = {1'b0, x[15:1]};
            endcase
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] d,
                        input logic [3:0] c, input logic [1:0] o);
        int p;
        rst = r; Start = s; In = d; Cnt = c; Op = o;
        @(posedge clk);
        if (r) begin
            m_bl = 0; m_done = 1'b0; m_out = 16'h0000;
        end else if (m_bl > 0) begin
            m_bl--;
            if (m_bl == 0) begin
                m_done = 1'b1;
                m_out  = m_res;
            end
        end else begin
            m_done = 1'b0;
            if (s) begin
                p     = $countones(c);
                m_bl  = (p == 0) ? 1 : p;
                m_res = ref_shift(d, c, o);
            end
        end
        #1;
        cyc++;
        chk("busy", 32'(Busy), 32'(m_bl > 0));
        chk("done", 32'(Done), 32'(m_done));
        if (m_bl == 0) chk("out", 32'(Out), 32'(m_out));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 2'($urandom));
    endtask

    // Accept one request, then wait (bounded) for Done; pin latency and result.
    task automatic run_dir(input string name, input logic [15:0] d, input logic [3:0] c,
                           input logic [1:0] o, input logic [15:0] exp_out, input int exp_lat);
        int n;
        step(1'b0, 1'b1, d, c, o);
        n = 0;
        while (!Done && n < 10) begin
            idle();
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(exp_lat));
        chk({name, "_out"}, 32'(Out), 32'(exp_out));
        idle();
    endtask

    initial begin
        step(1'b1, 1'b0, 16'h0, 4'h0, 2'h0);
        step(1'b1, 1'b1, 16'h1234, 4'h3, 2'h1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_out",  32'(Out),  32'h0000);
        idle();

        run_dir("rotl",  16'h8001, 4'd1,  2'b00, 16'h0003, 1);
        run_dir("sll15", 16'h00FF, 4'd15, 2'b01, 16'h8000, 4);
        run_dir("sra3",  16'h8000, 4'd3,  2'b10, 16'hF000, 2);
        run_dir("srl3",  16'h8000, 4'd3,  2'b11, 16'h1000, 2);
        run_dir("zero",  16'hA5A5, 4'd0,  2'b10, 16'hA5A5, 1);
        run_dir("rot12", 16'h1234, 4'd12, 2'b00, 16'h4123, 2);

        // Start held through RUN is ignored; re-accepted from DONE.
        step(1'b0, 1'b1, 16'h0001, 4'd7, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hFFFF, 4'd7, 2'b01);
        chk("hold_done1", 32'(Done), 32'd1);
        chk("hold_out1",  32'(Out),  32'h0080);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hFFFF, 4'd7, 2'b01);
        chk("hold_done2", 32'(Done), 32'd1);
        chk("hold_out2",  32'(Out),  32'hFF80);
        idle();
        idle();

        // Reset mid-operation discards the partial result.
        step(1'b0, 1'b1, 16'hBEEF, 4'd15, 2'b00);
        idle();
        step(1'b1, 1'b0, 16'h0, 4'h0, 2'h0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_out",  32'(Out),  32'h0000);
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("midrst_nodone", 32'(Done), 32'd0);
        end

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                 16'($urandom), 4'($urandom), 2'($urandom));
        end
        for (int i = 0; i < 8; i++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
